// File: rtl/bcd_display_scanner_if.sv
// Display-side bundle of the BCD scanner: the BCD word coming in from the
// memory-management stage and the anode/segment pins going out to the board.
interface bcd_display_scanner_if;
    logic [31:0] bcdDisplay;   // [31:28] sign nibble, [27:0] seven BCD digits
    logic [7:0]  anode;        // active-low digit enables, bit 0 = rightmost
    logic [6:0]  segments;     // active-low {g,f,e,d,c,b,a}
    logic        frameStart;   // one-cycle pulse at the start of position 0

    // Producer of the BCD word / observer of the display pins.
    modport master (
        output bcdDisplay,
        input  anode,
        input  segments,
        input  frameStart
    );

    // The scanner itself.
    modport slave (
        input  bcdDisplay,
        output anode,
        output segments,
        output frameStart
    );
endinterface : bcd_display_scanner_if

// File: rtl/bcd_display_scanner.sv
// Eight-digit common-anode seven-segment scanner. Snapshots the BCD display
// word once per refresh frame, then walks positions 0..7 with one slot of
// REFRESH_DIV cycles each. The first GUARD cycles of every slot keep all
// anodes dark so the previous digit's segments cannot ghost onto the next
// position. Position 7 carries the sign, positions 1..6 are leading-zero
// blanked, and non-decimal nibbles are shown as 'E'.
module bcd_display_scanner #(
    parameter int unsigned REFRESH_DIV = 50000,  // clk cycles per digit slot, >= 4
    parameter int unsigned GUARD       = 2       // dark cycles per slot, < REFRESH_DIV
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_display_scanner_if.slave  disp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);

    // Active-low glyphs {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;

    localparam logic [2:0] IDX_LAST = 3'd7;

    // Seven-segment code for a decimal digit; non-decimal values map to 'E'
    // so the function is total even though callers filter them first.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,          cnt_d;           // cycle within slot
    logic [2:0]       idx_q,          idx_d;           // display position
    logic [31:0]      snap_q,         snap_d;          // frame snapshot
    logic             load_pending_q, load_pending_d;  // first load after reset
    logic [7:0]       anode_q,        anode_d;
    logic [6:0]       seg_q,          seg_d;

    logic             slot_end;
    logic             frame_end;
    logic [27:0]      upper;      // snapshot digits from the current position up
    logic [3:0]       nibble;     // digit at the current position (idx 0..6)

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Slot counter, position index and snapshot capture.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        snap_d         = snap_q;
        load_pending_d = load_pending_q;

        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;          // 7 wraps to 0 in three bits
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // The word is captured only at frame boundaries (and once straight
        // after reset), so mid-frame changes never tear the current frame.
        if (load_pending_q || frame_end) begin
            snap_d         = disp.bcdDisplay;
            load_pending_d = 1'b0;
        end
    end

    // Glyph selection for the current position and the guarded anode pattern.
    always_comb begin
        seg_d   = GLYPH_BLANK;
        anode_d = 8'hFF;
        upper   = snap_q[27:0] >> {idx_q, 2'b00};
        nibble  = upper[3:0];

        if (idx_q == IDX_LAST) begin
            seg_d = (snap_q[31:28] != 4'h0) ? GLYPH_MINUS : GLYPH_BLANK;
        end else if ((idx_q != 3'd0) && (upper == 28'd0)) begin
            // This digit and everything to its left are zero: leading zero.
            seg_d = GLYPH_BLANK;
        end else if (nibble > 4'd9) begin
            seg_d = GLYPH_E;
        end else begin
            seg_d = digit_glyph(nibble);
        end

        if (cnt_q >= GUARD_C) begin
            anode_d = ~(8'b0000_0001 << idx_q);
        end
    end

    // State and registered display outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            snap_q         <= '0;
            load_pending_q <= 1'b1;
            anode_q        <= 8'hFF;
            seg_q          <= GLYPH_BLANK;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            load_pending_q <= load_pending_d;
            anode_q        <= anode_d;
            seg_q          <= seg_d;
        end
    end

    assign disp.anode      = anode_q;
    assign disp.segments   = seg_q;
    // Position 0 slot begins whenever the scan state sits at (0,0); gated by
    // reset so the pulse is held low while reset is asserted.
    assign disp.frameStart = !reset && (cnt_q == '0) && (idx_q == 3'd0);

endmodule : bcd_display_scanner

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner with REFRESH_DIV=4, GUARD=1.
// The driver issues one cycle of stimulus at a time and pushes the expected
// display pins for that cycle, derived from the cycle's age since reset and
// the frame snapshot; a separate monitor pops and compares on every falling
// edge, and also checks that frameStart pulses are 32 cycles apart.
module tb_bcd_display_scanner;

    localparam int RD    = 4;
    localparam int GD    = 1;
    localparam int FRAME = 8 * RD;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bcd_display_scanner_if disp ();

    bcd_display_scanner #(
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] anode;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // What position pos shows for word w, straight from the display rules.
    function automatic logic [6:0] ref_glyph(input logic [31:0] w, input int pos);
        int unsigned val;
        int unsigned higher;
        int unsigned nib;
        if (pos == 7) return (w[31:28] != 4'h0) ? 7'b0111111 : 7'b1111111;
        val    = {4'h0, w[27:0]};
        higher = val / (16 ** pos);          // this digit and all to its left
        nib    = higher % 16;
        if (pos != 0 && higher == 0) return 7'b1111111;
        if (nib > 9) return 7'b0000110;
        return DIGITS[nib];
    endfunction

    // Reference model: u = cycles since the last reset edge.
    int          u;
    logic        prev_rst;
    logic [31:0] snap_cur;   // snapshot held during cycle u
    logic [31:0] snap_prev;  // snapshot held during cycle u-1

    task automatic step(input logic rst, input logic [31:0] word);
        exp_t e;
        int   v;
        @(posedge clk);
        #1;
        reset           = rst;
        disp.bcdDisplay = word;

        if (prev_rst) begin
            u        = 0;
            snap_cur = 32'h0;
        end

        e.fs = !rst && (u % FRAME == 0);
        if (u == 0) begin
            e.anode = 8'hFF;
            e.seg   = 7'h7F;
        end else begin
            v       = u - 1;         // outputs show the previous cycle's scan
            e.anode = ((v % RD) < GD) ? 8'hFF : ~(8'(1) << ((v / RD) % 8));
            e.seg   = ref_glyph(snap_prev, (v / RD) % 8);
        end
        sb_q.push_back(e);

        // Snapshot is taken at the end of the first cycle after reset and at
        // the end of the last cycle of every frame.
        snap_prev = snap_cur;
        if (u == 0 || u % FRAME == FRAME - 1) snap_cur = word;
        u        = u + 1;
        prev_rst = rst;
    endtask

    task automatic run(input int n, input logic [31:0] word);
        for (int i = 0; i < n; i++) step(1'b0, word);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int          ndig;
        w    = '0;
        ndig = $urandom_range(0, 7);
        for (int k = 0; k < ndig; k++) begin
            w[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 1) == 1) w[31:28] = 4'($urandom_range(1, 15));
        return w;
    endfunction

    // Monitor: compare each cycle's pins against the scoreboard head.
    int cyc     = 0;
    int last_fs = -1;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("anode",      32'(disp.anode),      32'(e.anode));
                check("segments",   32'(disp.segments),   32'(e.seg));
                check("frameStart", 32'(disp.frameStart), 32'(e.fs));
            end
            if (reset === 1'b1) begin
                last_fs = -1;
            end else if (disp.frameStart === 1'b1) begin
                if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
                last_fs = cyc;
            end
        end
    end

    // Driver: directed scenarios, then randomized words and resets.
    initial begin
        logic rst;
        disp.bcdDisplay = 32'h0000_0123;
        prev_rst        = 1'b1;
        u               = 0;
        snap_cur        = '0;
        snap_prev       = '0;

        repeat (3) step(1'b1, 32'h0000_0123);
        run(2 * FRAME, 32'h0000_0123);
        run(2 * FRAME, 32'hF000_0045);

        // Word changes while the scan is at position 3.
        run(FRAME + 3 * RD, 32'h0000_0001);
        run(5 * RD + FRAME, 32'h0000_0009);

        run(FRAME, 32'h0000_0000);
        run(FRAME, 32'h0000_0100);
        run(FRAME, 32'h0000_00A0);
        run(FRAME, 32'h0000_000C);
        run(FRAME, 32'h0000_000C);

        // Reset for one cycle while the scan is at position 5.
        run(5 * RD, 32'h0000_0777);
        step(1'b1, 32'h0000_0555);
        run(3 * FRAME, 32'h8765_4321);

        for (int i = 0; i < 30 * FRAME; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            step(rst, rand_word());
        end
        run(2 * FRAME, 32'h0000_0042);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_display_scanner

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the memory-management stage's 32-bit BCD display word.
- Snapshots the word once per refresh frame and time-multiplexes it onto an 8-digit common-anode seven-segment display.
- Applies sign, leading-zero blanking, invalid-digit marking and inter-digit ghosting guard.
- Only block that drives the board's anode and segment pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; minimum 4.
- GUARD, 2: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock; one clock domain.
- reset  input  1  synchronous, active-high reset.
- bcdDisplay  input  32  [31:28] sign nibble (nonzero = negative); [27:0] seven BCD digits, digit0 at [3:0].
- anode  output  8  active-low digit enables; bit k = position k, position 0 rightmost.
- segments  output  7  active-low {g,f,e,d,c,b,a}.
- frameStart  output  1  one-cycle pulse when position 0 slot begins.

Behaviour:
- Reset: all of the following hold while reset is high, on the clk edge.
  - Slot counter = 0, index = 0, snapshot = 0.
  - loadPending = 1, anode = 8'hFF, segments = 7'h7F, frameStart = 0.
- Slot counter counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and index advances; 7 wraps to 0.
- Snapshot load: snapshot <= bcdDisplay on the cycle index advances 7->0, or on the first cycle after reset when loadPending = 1, which then clears. bcdDisplay changes mid-frame never affect the current frame.
- frameStart = 1 for exactly one cycle, the cycle in which slot counter = 0 and index = 0, including the first slot after reset.
- Glyph for position k, in priority order:
  - k=7: minus 7'b0111111 if sign nibble != 0, else blank 7'b1111111.
  - k=0: nibble 0 always displayed.
  - k=1..6: blank if nibbles k..6 of the snapshot are all zero. This blanking is evaluated before the invalid-digit check.
  - Otherwise, nibble > 9: 'E' 7'b0000110.
  - Otherwise, digit code: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
- Negative zero shows '-' at position 7 and '0' at position 0; no normalisation.
- Guard: while slot counter < GUARD, anode = 8'hFF. Otherwise anode = ~(1 << index).
- Outputs are registered: anode and segments reflect counter, index and snapshot from the previous cycle, a one-cycle latency.
- segments carries the glyph of the current index even during guard cycles.
- Reset asserted mid-frame or mid-slot: immediate return to reset values on the next edge. The next frame starts from position 0 with a fresh snapshot.
- No handshake: bcdDisplay is sampled only at snapshot instants and needs only to be stable at those edges.

Test Plan:
- (All scenarios use REFRESH_DIV=4, GUARD=1.)
- Reset behaviour: hold reset 3 cycles with bcdDisplay=32'h0000_0123, then release.
  - anode=FF and segments=7F during reset.
  - frameStart pulses in the first cycle after release.
  - Position 0 slot shows '3' (0110000) with anode=FE from slot cycle 1 (plus one-cycle output latency).
  - Positions 1 and 2 show '2' and '1'; positions 3..7 are blank.
- Sign: bcdDisplay=32'hF000_0045.
  - Position 7 shows 0111111, position 1 shows '4', position 0 shows '5'.
  - Positions 2..6 are blank.
- Snapshot isolation: change bcdDisplay from 32'h0000_0001 to 32'h0000_0009 while index=3.
  - The remainder of that frame still shows '1' at position 0.
  - The next frame shows '9'.
- Zero and blanking: bcdDisplay=32'h0000_0000 shows '0' only at position 0; 32'h0000_0100 shows '1','0','0' at positions 2..0.
- Invalid digit: bcdDisplay=32'h0000_00A0.
  - Position 1 shows E (0000110), position 0 shows '0'.
  - 32'h0000_000C shows E at position 0.
- Mid-frame reset: assert reset for 1 cycle at index=5.
  - Next cycle anode=FF.
  - Scan restarts at index 0 with frameStart and a new snapshot.
  - Frame period is 32 cycles thereafter, checked by frameStart spacing.
